division_unit: RTL and testbench

- Iterative radix-2 integer divider for the RV32M DIV, DIVU, REM and REMU operations.
- Consumes the DIV subunit opcode of the integer-unit uop (2-bit div_uop_t) together with the operands and a reorder tag from the integer issue stage.
- Returns one 32-bit result per accepted operation to integer writeback.
- Single-issue and non-pipelined: it holds at most one operation at a time.

---
 rtl/division_unit.sv | 166 ++++++++++++++++
 tb/tb_division_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/division_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Holds one operation at a time. Divide-by-zero and signed overflow
// finish in two cycles. All other operations finish after 32 shift/subtract steps.
module division_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  data_valid_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  logic [1:0]            operation_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [TAG_WIDTH-1:0]  tag_o,
   output logic                  data_valid_o,
   output logic                  idle_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DIVIDE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Magnitude of a two's-complement value. The most negative value maps to itself, which is its correct unsigned magnitude.
   function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] v);
      logic signed [DATA_WIDTH-1:0] neg;
      neg = -v;
      return v[DATA_WIDTH-1] ? $unsigned(neg) : $unsigned(v);
   endfunction

   // Applies the recorded sign to an unsigned magnitude.
   function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                        input logic                  neg);
      logic signed [DATA_WIDTH-1:0] t;
      t = -$signed(mag);
      return neg ? $unsigned(t) : mag;
   endfunction

   state_t                state_r, state_nxt;
   logic [CNT_W-1:0]      cnt_r;
   logic                  accept;
   logic                  finish;

   // Operation latched at acceptance and the working divider state
   logic [DATA_WIDTH-1:0] rem_r;
   logic [DATA_WIDTH-1:0] quo_r;
   logic [DATA_WIDTH-1:0] dvs_r;
   logic                  is_rem_r;
   logic                  q_neg_r;
   logic                  r_neg_r;
   logic [TAG_WIDTH-1:0]  tag_r;

   // Decode of the incoming operation. Bit 0 of the opcode selects unsigned. Bit 1 selects remainder.
   logic                  op_signed;
   logic                  div_zero;
   logic                  sgn_ovf;
   logic                  special;
   logic signed [DATA_WIDTH-1:0] dvd_s;
   logic signed [DATA_WIDTH-1:0] dvs_s;

   assign op_signed = ~operation_i[0];
   assign dvd_s     = $signed(dividend_i);
   assign dvs_s     = $signed(divisor_i);
   assign div_zero  = (divisor_i == '0);
   assign sgn_ovf   = op_signed && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);
   assign special   = div_zero | sgn_ovf;

   // One restoring step. Shift {rem, quo} left, then trial-subtract the divisor.
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;
   logic                  diff_neg;
   assign shifted  = {rem_r, quo_r[DATA_WIDTH-1]};
   assign diff     = shifted - {1'b0, dvs_r};
   assign diff_neg = diff[DATA_WIDTH];

   // Final result selection with sign correction
   logic [DATA_WIDTH-1:0] final_res;
   assign final_res = is_rem_r ? apply_sign(rem_r, r_neg_r) : apply_sign(quo_r, q_neg_r);

   // Next-state and handshake decode. Flush overrides every transition.
   always_comb begin
      state_nxt = state_r;
      accept    = 1'b0;
      finish    = 1'b0;
      idle_o    = (state_r == S_IDLE);
      case (state_r)
         S_IDLE: begin
            if (data_valid_i) begin
               accept    = 1'b1;
               state_nxt = special ? S_DONE : S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            if (cnt_r == CNT_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush_i) begin
         accept    = 1'b0;
         finish    = 1'b0;
         state_nxt = S_IDLE;
      end
   end

   // Control state, iteration counter and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= S_IDLE;
         cnt_r        <= '0;
         data_valid_o <= 1'b0;
         result_o     <= '0;
         tag_o        <= '0;
      end else begin
         state_r      <= state_nxt;
         data_valid_o <= finish;
         if (accept || flush_i) cnt_r <= '0;
         else if (state_r == S_DIVIDE) cnt_r <= cnt_r + 1'b1;
         if (finish) begin
            result_o <= final_res;
            tag_o    <= tag_r;
         end
      end
   end

   // Operand capture at acceptance, then one divide step per DIVIDE cycle
   always_ff @(posedge clk_i) begin
      if (accept) begin
         tag_r    <= tag_i;
         is_rem_r <= operation_i[1];
         dvs_r    <= op_signed ? abs_val(dvs_s) : divisor_i;
         if (div_zero) begin
            quo_r   <= ALL_ONES;
            rem_r   <= dividend_i;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
         end else if (sgn_ovf) begin
            quo_r   <= MIN_NEG;
            rem_r   <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
         end else begin
            quo_r   <= op_signed ? abs_val(dvd_s) : dividend_i;
            rem_r   <= '0;
            q_neg_r <= op_signed & (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
            r_neg_r <= op_signed & dividend_i[DATA_WIDTH-1];
         end
      end else if (state_r == S_DIVIDE) begin
         rem_r <= diff_neg ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
         quo_r <= {quo_r[DATA_WIDTH-2:0], ~diff_neg};
      end
   end

endmodule

// File: tb/tb_division_unit.sv
// Scoreboard bench for division_unit. The stimulus pushes expected completions into a queue. A monitor pops an entry whenever data_valid_o is high.
module tb_division_unit;

   localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        data_valid_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic [1:0]  operation_i = '0;
   logic [5:0]  tag_i = '0;
   logic [31:0] result_o;
   logic [5:0]  tag_o;
   logic        data_valid_o;
   logic        idle_o;

   typedef struct {
      logic [31:0] res;
      logic [5:0]  tag;
      int          cyc;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   division_unit #(.DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .data_valid_i(data_valid_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .operation_i(operation_i),
      .tag_i(tag_i), .result_o(result_o), .tag_o(tag_o),
      .data_valid_o(data_valid_o), .idle_o(idle_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // RISC-V division semantics, computed with plain 64-bit arithmetic
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output bit special);
      longint sa, sb_, ua, ub, r;
      special = 1'b1;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      special = 1'b0;
      sa = $signed(a);
      sb_ = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_DIV:  r = sa / sb_;
         OP_REM:  r = sa % sb_;
         OP_DIVU: r = ua / ub;
         default: r = ua % ub;
      endcase
      return 32'(r);
   endfunction

   // Monitor: every valid result must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (data_valid_o) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", {31'd0, data_valid_o}, 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("result", result_o, e.res);
            check("tag", {26'd0, tag_o}, {26'd0, e.tag});
            check("latency", cyc, e.cyc);
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tg, input bit track, output int acc);
      int n = 0;
      bit sp;
      sb_t e;
      while (!idle_o && n < 200) begin @(posedge clk); #1; n++; end
      check("idle_wait", {31'd0, idle_o}, 32'd1);
      operation_i  = op;
      dividend_i   = a;
      divisor_i    = b;
      tag_i        = tg;
      data_valid_i = 1'b1;
      acc = cyc;
      if (track) begin
         e.res = ref_div(op, a, b, sp);
         e.tag = tg;
         e.cyc = acc + (sp ? 2 : 34);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      data_valid_i = 1'b0;
      check("busy_after_accept", {31'd0, idle_o}, 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      check("drain_timeout", sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int c;
      int c2;
      logic [31:0] a, b;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", result_o, 32'd0);
      check("reset_tag", {26'd0, tag_o}, 32'd0);
      check("reset_valid", {31'd0, data_valid_o}, 32'd0);
      check("reset_idle", {31'd0, idle_o}, 32'd1);
      rst_i = 1'b0;
      @(posedge clk); #1;

      // Basic signed/unsigned quotient and remainder
      issue(OP_DIV,  32'd100, 32'd7, 6'h05, 1'b1, c);
      issue(OP_REM,  32'd100, 32'd7, 6'h06, 1'b1, c);
      issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 6'h07, 1'b1, c);
      issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 6'h08, 1'b1, c);
      issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 6'h09, 1'b1, c);
      issue(OP_REMU, 32'hFFFF_FFF9, 32'd2, 6'h0A, 1'b1, c);
      drain();

      // Special cases: two-cycle latency, idle again in cycle 2
      issue(OP_DIVU, 32'd5, 32'd0, 6'h11, 1'b1, c);
      wait_until(c + 2);
      check("special_idle_c2", {31'd0, idle_o}, 32'd1);
      issue(OP_REM,  32'd5, 32'd0, 6'h12, 1'b1, c);
      issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'h13, 1'b1, c);
      issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 6'h14, 1'b1, c);
      issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 6'h15, 1'b1, c);
      drain();

      // Flush mid-divide, then a new operation right after
      issue(OP_DIV, 32'd1000, 32'd10, 6'h20, 1'b0, c);
      wait_until(c + 10);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_idle", {31'd0, idle_o}, 32'd1);
      issue(OP_DIVU, 32'd9, 32'd3, 6'h21, 1'b1, c2);
      check("flush_reissue_cycle", c2, c + 11);
      drain();

      // Flush in the completion cycle discards the result
      issue(OP_DIV, 32'd50, 32'd5, 6'h22, 1'b0, c);
      wait_until(c + 33);
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_done_valid", {31'd0, data_valid_o}, 32'd0);
      check("flush_done_idle", {31'd0, idle_o}, 32'd1);

      // Flush together with a request in IDLE: nothing is accepted
      flush_i = 1'b1;
      data_valid_i = 1'b1;
      dividend_i = 32'd5;
      divisor_i = 32'd0;
      @(posedge clk); #1;
      flush_i = 1'b0;
      data_valid_i = 1'b0;
      check("flush_wins_idle", {31'd0, idle_o}, 32'd1);
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a divide
      issue(OP_DIV, 32'd777, 32'd3, 6'h30, 1'b0, c);
      wait_until(c + 20);
      rst_i = 1'b1;
      #1;
      check("rst_result", result_o, 32'd0);
      check("rst_tag", {26'd0, tag_o}, 32'd0);
      check("rst_valid", {31'd0, data_valid_o}, 32'd0);
      check("rst_idle", {31'd0, idle_o}, 32'd1);
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(posedge clk); #1;
      issue(OP_REMU, 32'd17, 32'd5, 6'h31, 1'b1, c);
      drain();

      // A request while busy is ignored
      issue(OP_DIV, 32'hFFFF_FC18, 32'd7, 6'h32, 1'b1, c);
      wait_until(c + 5);
      operation_i = OP_REMU;
      dividend_i = 32'd99;
      divisor_i = 32'd0;
      tag_i = 6'h3F;
      data_valid_i = 1'b1;
      @(posedge clk); #1;
      data_valid_i = 1'b0;
      drain();

      // Randomized operations with biased operand corners
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: a = 32'd0;
            1: a = 32'h8000_0000;
            2: a = 32'hFFFF_FFFF;
            3: a = $urandom_range(0, 255);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'd1;
            3: b = $urandom_range(1, 15);
            4: b = 32'h8000_0000;
            default: b = $urandom;
         endcase
         issue(2'($urandom_range(0, 3)), a, b, 6'($urandom), 1'b1, c);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
